bit_lane_coalescer: RTL and testbench



---
 rtl/bit_lane_coalescer.sv | 234 +++++++++++++++++++++++
 tb/tb_bit_lane_coalescer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_lane_coalescer.sv
// bit_lane_coalescer
//   Gathers single-bit lane writes (group, lane, value) arriving in any order
//   into per-group WIDTH-bit vectors. A group that has every lane written turns
//   FULL one cycle later. A round-robin arbiter then hands FULL groups to the
//   single vector output port.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   lane write request
//   in_ready   write accepted when in_valid && in_ready (0 iff target group FULL)
//   in_group   target group index
//   in_index   target lane index
//   in_bit     lane value
//   out_valid  a FULL group is being offered
//   out_ready  consumer accepts the offered vector
//   out_group  group of the offered vector
//   out_data   offered vector, bit i = lane i
//   err_dup    one-cycle pulse after a duplicate or out-of-range write
//   busy       some group holds at least one written lane
//
// Optional feature, macro BIT_LANE_COALESCER_FLUSH_EN:
//   flush      force every group with a non-zero mask to FULL at the next edge
//   out_mask   lane mask of the offered group (valid lanes of a flushed vector)
module bit_lane_coalescer #(
  parameter  int WIDTH      = 4,
  parameter  int NUM_GROUPS = 2,
  localparam int GW         = $clog2(NUM_GROUPS),
  localparam int IW         = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [GW-1:0]    in_group,
  input  logic [IW-1:0]    in_index,
  input  logic             in_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [GW-1:0]    out_group,
  output logic [WIDTH-1:0] out_data,
`ifdef BIT_LANE_COALESCER_FLUSH_EN
  input  logic             flush,
  output logic [WIDTH-1:0] out_mask,
`endif
  output logic             err_dup,
  output logic             busy
);

  logic [WIDTH-1:0]      data_r     [NUM_GROUPS];
  logic [WIDTH-1:0]      mask_r     [NUM_GROUPS];
  logic [NUM_GROUPS-1:0] full_r;
  logic [GW-1:0]         rr_r;
  logic                  lock_r;
  logic [GW-1:0]         lock_grp_r;
  logic                  err_dup_r;

  logic [WIDTH-1:0]      data_nxt_s [NUM_GROUPS];
  logic [WIDTH-1:0]      mask_nxt_s [NUM_GROUPS];
  logic [NUM_GROUPS-1:0] full_nxt_s;
  logic                  grp_ok_s;
  logic                  lane_ok_s;
  logic                  wr_s;
  logic                  wr_hit_s;
  logic                  dup_s;
  logic                  any_full_s;
  logic                  hs_s;
  logic                  found_s;
  logic [GW-1:0]         search_s;
  logic [GW-1:0]         grant_s;
  logic                  flush_s;

`ifdef BIT_LANE_COALESCER_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  // Range decode of the incoming write address (non-power-of-two sizes).
  always_comb begin
    grp_ok_s  = (32'(in_group) < NUM_GROUPS);
    lane_ok_s = (32'(in_index) < WIDTH);
  end

  // Back-pressure: only a FULL target group stalls; out-of-range writes are
  // always accepted so they can be dropped and flagged.
  always_comb begin
    if (grp_ok_s) begin
      in_ready = ~full_r[in_group];
    end else begin
      in_ready = 1'b1;
    end
  end

  // Write qualification and duplicate / out-of-range detection.
  always_comb begin
    wr_s     = in_valid & in_ready;
    wr_hit_s = wr_s & grp_ok_s & lane_ok_s;
    dup_s    = 1'b0;
    if (wr_s) begin
      if (grp_ok_s && lane_ok_s) begin
        dup_s = mask_r[in_group][in_index];
      end else begin
        dup_s = 1'b1;
      end
    end else begin
      dup_s = 1'b0;
    end
  end

  // Round-robin search: first FULL group upward from rr_r+1, wrapping.
  always_comb begin
    int            cand;
    logic [GW-1:0] cand_g;
    cand     = 0;
    cand_g   = '0;
    found_s  = 1'b0;
    search_s = '0;
    for (int k = 1; k <= NUM_GROUPS; k++) begin
      cand = int'(rr_r) + k;
      if (cand >= NUM_GROUPS) begin
        cand = cand - NUM_GROUPS;
      end else begin
        cand = cand;
      end
      cand_g = cand[GW-1:0];
      if (!found_s && full_r[cand_g]) begin
        found_s  = 1'b1;
        search_s = cand_g;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Grant is frozen while an offered vector waits on out_ready.
  always_comb begin
    any_full_s = |full_r;
    if (lock_r) begin
      grant_s = lock_grp_r;
    end else begin
      grant_s = search_s;
    end
    hs_s = any_full_s & out_ready;
  end

  // Output view of the granted group, zero when nothing is offered.
  always_comb begin
    out_valid = any_full_s;
    if (any_full_s) begin
      out_group = grant_s;
      out_data  = data_r[grant_s];
    end else begin
      out_group = '0;
      out_data  = '0;
    end
  end

`ifdef BIT_LANE_COALESCER_FLUSH_EN
  // Lane mask of the granted group, so partial flushed vectors can be decoded.
  always_comb begin
    if (any_full_s) begin
      out_mask = mask_r[grant_s];
    end else begin
      out_mask = '0;
    end
  end
`endif

  // Next-state per group. FULL follows an all-ones mask by one cycle; a flush
  // uses the post-write mask so a same-cycle write is included.
  always_comb begin
    for (int g = 0; g < NUM_GROUPS; g++) begin
      data_nxt_s[g] = data_r[g];
      mask_nxt_s[g] = mask_r[g];
    end
    if (wr_hit_s) begin
      data_nxt_s[in_group][in_index] = in_bit;
      mask_nxt_s[in_group][in_index] = 1'b1;
    end else begin
      data_nxt_s[0] = data_nxt_s[0];
    end
    for (int g = 0; g < NUM_GROUPS; g++) begin
      full_nxt_s[g] = full_r[g] | (&mask_r[g]) | (flush_s & (|mask_nxt_s[g]));
      if (hs_s && (grant_s == GW'(g))) begin
        data_nxt_s[g] = '0;
        mask_nxt_s[g] = '0;
        full_nxt_s[g] = 1'b0;
      end else begin
        full_nxt_s[g] = full_nxt_s[g];
      end
    end
  end

  // Busy whenever any lane of any group has been written.
  always_comb begin
    busy = 1'b0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      busy = busy | (|mask_r[g]);
    end
  end

  assign err_dup = err_dup_r;

  // State registers; rr starts at the last group so group 0 is served first.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int g = 0; g < NUM_GROUPS; g++) begin
        data_r[g] <= '0;
        mask_r[g] <= '0;
      end
      full_r     <= '0;
      rr_r       <= GW'(NUM_GROUPS - 1);
      lock_r     <= 1'b0;
      lock_grp_r <= '0;
      err_dup_r  <= 1'b0;
    end else begin
      for (int g = 0; g < NUM_GROUPS; g++) begin
        data_r[g] <= data_nxt_s[g];
        mask_r[g] <= mask_nxt_s[g];
      end
      full_r     <= full_nxt_s;
      err_dup_r  <= dup_s;
      lock_r     <= any_full_s & ~out_ready;
      lock_grp_r <= grant_s;
      if (hs_s) begin
        rr_r <= grant_s;
      end else begin
        rr_r <= rr_r;
      end
    end
  end

endmodule

// File: tb/tb_bit_lane_coalescer.sv
// Directed testbench for bit_lane_coalescer (WIDTH=4, NUM_GROUPS=2).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_bit_lane_coalescer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [0:0] in_group;
  logic [1:0] in_index;
  logic       in_bit;
  logic       out_valid;
  logic       out_ready;
  logic [0:0] out_group;
  logic [3:0] out_data;
  logic       err_dup;
  logic       busy;
`ifdef BIT_LANE_COALESCER_FLUSH_EN
  logic       flush = 1'b0;
  logic [3:0] out_mask;
`endif

  int errors = 0;
  int checks = 0;

  bit_lane_coalescer #(.WIDTH(4), .NUM_GROUPS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_group  (in_group),
    .in_index  (in_index),
    .in_bit    (in_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_group (out_group),
    .out_data  (out_data),
`ifdef BIT_LANE_COALESCER_FLUSH_EN
    .flush     (flush),
    .out_mask  (out_mask),
`endif
    .err_dup   (err_dup),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One accepted lane write (target group must not be FULL).
  task automatic wr(input logic g, input logic [1:0] i, input logic b);
    in_valid = 1'b1;
    in_group = g;
    in_index = i;
    in_bit   = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_group  = 1'b0;
    in_index  = 2'd0;
    in_bit    = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_group", out_group, 1'b0);
    chk("rst_out_data",  out_data,  4'b0000);
    chk("rst_busy",      busy,      1'b0);
    chk("rst_err_dup",   err_dup,   1'b0);
    chk("rst_in_ready",  in_ready,  1'b1);

    // 1. Out-of-order fill of group 0: lanes 2,0,3,1 = 1,0,1,1
    wr(1'b0, 2'd2, 1'b1);
    wr(1'b0, 2'd0, 1'b0);
    wr(1'b0, 2'd3, 1'b1);
    wr(1'b0, 2'd1, 1'b1);
    chk("t1_not_yet_valid", out_valid, 1'b0);
    chk("t1_busy_filling",  busy,      1'b1);
    @(negedge clk);
    chk("t1_out_valid", out_valid, 1'b1);
    chk("t1_out_group", out_group, 1'b0);
    chk("t1_out_data",  out_data,  4'b1110);
    @(negedge clk);
    chk("t1_drained_valid", out_valid, 1'b0);
    chk("t1_drained_busy",  busy,      1'b0);

    // 2. Interleaved groups; group 0 completes one cycle before group 1
    wr(1'b0, 2'd1, 1'b1);
    wr(1'b1, 2'd0, 1'b1);
    wr(1'b0, 2'd0, 1'b0);
    wr(1'b1, 2'd1, 1'b0);
    wr(1'b0, 2'd2, 1'b0);
    wr(1'b1, 2'd2, 1'b0);
    wr(1'b0, 2'd3, 1'b0);
    wr(1'b1, 2'd3, 1'b0);
    chk("t2_g0_valid", out_valid, 1'b1);
    chk("t2_g0_group", out_group, 1'b0);
    chk("t2_g0_data",  out_data,  4'b0010);
    @(negedge clk);
    chk("t2_g1_valid", out_valid, 1'b1);
    chk("t2_g1_group", out_group, 1'b1);
    chk("t2_g1_data",  out_data,  4'b0001);
    @(negedge clk);
    chk("t2_idle_valid", out_valid, 1'b0);
    chk("t2_idle_busy",  busy,      1'b0);

    // 3. Both groups FULL under back-pressure; group 0 = 0101, group 1 = 1010
    out_ready = 1'b0;
    wr(1'b0, 2'd0, 1'b1);
    wr(1'b1, 2'd0, 1'b0);
    wr(1'b0, 2'd1, 1'b0);
    wr(1'b1, 2'd1, 1'b1);
    wr(1'b0, 2'd2, 1'b1);
    wr(1'b1, 2'd2, 1'b0);
    wr(1'b0, 2'd3, 1'b0);
    wr(1'b1, 2'd3, 1'b1);
    for (int c = 0; c < 3; c++) begin
      chk("t3_hold_valid", out_valid, 1'b1);
      chk("t3_hold_group", out_group, 1'b0);
      chk("t3_hold_data",  out_data,  4'b0101);
      if (c < 2) @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_next_group", out_group, 1'b1);
    chk("t3_next_data",  out_data,  4'b1010);
    @(negedge clk);
    chk("t3_empty_valid", out_valid, 1'b0);
    // Refill: group 1 (0011) completes first, then higher-priority group 0 (1100)
    out_ready = 1'b0;
    wr(1'b0, 2'd0, 1'b0);
    wr(1'b1, 2'd0, 1'b1);
    wr(1'b0, 2'd1, 1'b0);
    wr(1'b1, 2'd1, 1'b1);
    wr(1'b0, 2'd2, 1'b1);
    wr(1'b1, 2'd2, 1'b0);
    wr(1'b1, 2'd3, 1'b0);
    wr(1'b0, 2'd3, 1'b1);
    chk("t3_lock_group_a", out_group, 1'b1);
    chk("t3_lock_data_a",  out_data,  4'b0011);
    @(negedge clk);
    chk("t3_lock_group_b", out_group, 1'b1);
    chk("t3_lock_data_b",  out_data,  4'b0011);
    @(negedge clk);
    chk("t3_lock_group_c", out_group, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_g0_wins_group", out_group, 1'b0);
    chk("t3_g0_wins_data",  out_data,  4'b1100);
    @(negedge clk);
    chk("t3_final_valid", out_valid, 1'b0);
    chk("t3_final_busy",  busy,      1'b0);

    // 4. Duplicate write to group 0 lane 1
    wr(1'b0, 2'd1, 1'b0);
    chk("t4_first_no_dup", err_dup, 1'b0);
    wr(1'b0, 2'd1, 1'b1);
    chk("t4_dup_pulse", err_dup, 1'b1);
    @(negedge clk);
    chk("t4_dup_cleared",   err_dup,   1'b0);
    chk("t4_partial_valid", out_valid, 1'b0);
    wr(1'b0, 2'd0, 1'b0);
    chk("t4_no_dup_lane0", err_dup, 1'b0);
    wr(1'b0, 2'd2, 1'b0);
    wr(1'b0, 2'd3, 1'b0);
    chk("t4_not_yet_valid", out_valid, 1'b0);
    @(negedge clk);
    chk("t4_valid", out_valid, 1'b1);
    chk("t4_data",  out_data,  4'b0010);
    @(negedge clk);
    chk("t4_busy_done", busy, 1'b0);

    // 5. Back-pressure on a FULL group 0 (1001); group 1 still writable
    out_ready = 1'b0;
    wr(1'b0, 2'd0, 1'b1);
    wr(1'b0, 2'd1, 1'b0);
    wr(1'b0, 2'd2, 1'b0);
    wr(1'b0, 2'd3, 1'b1);
    @(negedge clk);
    chk("t5_valid", out_valid, 1'b1);
    in_valid = 1'b1;
    in_group = 1'b0;
    in_index = 2'd0;
    in_bit   = 1'b0;
    #1;
    chk("t5_stall_a", in_ready, 1'b0);
    @(negedge clk);
    #1;
    chk("t5_stall_b",     in_ready, 1'b0);
    chk("t5_stable_data", out_data, 4'b1001);
    in_group = 1'b1;
    in_bit   = 1'b1;
    #1;
    chk("t5_g1_ready", in_ready, 1'b1);
    @(negedge clk);
    in_group  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("t5_no_bypass",   in_ready,  1'b0);
    chk("t5_still_valid", out_valid, 1'b1);
    @(negedge clk);
    #1;
    chk("t5_ready_after_hs", in_ready,  1'b1);
    chk("t5_valid_after_hs", out_valid, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t5_busy", busy, 1'b1);

    // 6. Reset mid-fill: group 0 holds lanes 0..2, group 1 holds lane 0
    wr(1'b0, 2'd1, 1'b1);
    wr(1'b0, 2'd2, 1'b1);
    chk("t6_busy_before", busy,      1'b1);
    chk("t6_valid_before", out_valid, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_busy_after_rst",  busy,      1'b0);
    chk("t6_valid_after_rst", out_valid, 1'b0);
    wr(1'b0, 2'd3, 1'b1);
    chk("t6_busy_lane3", busy, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t6_no_output", out_valid, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
